// File: rtl/alu_result_stage.sv
// Registered result stage behind the ALU: 2-entry ordered buffer with valid/ready
// handshake, B-operand feedback, accept counter and sticky add-overflow flag.
module alu_result_stage #(
    parameter int N = 4
) (
    input  logic           Clock,
    input  logic           Reset_b,
    input  logic           Clear,
    input  logic [2*N-1:0] ALUout,
    input  logic [1:0]     Function,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [2*N-1:0] Result,
    output logic [1:0]     FuncOut,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   B_fb,
    output logic [7:0]     OpCount,
    output logic           Overflow
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_wptr;
    logic           r_rptr;
    logic [2*N-1:0] r_data [2];
    logic [1:0]     r_func [2];
    logic [N-1:0]   r_bfb;
    logic [7:0]     r_opcnt;
    logic           r_ovf;

    logic           w_push;
    logic           w_pop;

    assign in_ready  = (r_state != FULL) && !Clear;
    assign out_valid = (r_state != EMPTY);
    assign w_push    = in_valid && in_ready;
    // Clear drops any pop offered in the same cycle.
    assign w_pop     = out_valid && out_ready && !Clear;

    assign Result    = r_data[r_rptr];
    assign FuncOut   = r_func[r_rptr];
    assign B_fb      = r_bfb;
    assign OpCount   = r_opcnt;
    assign Overflow  = r_ovf;

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            r_state   <= EMPTY;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_func[0] <= '0;
            r_func[1] <= '0;
            r_bfb     <= '0;
            r_opcnt   <= '0;
            r_ovf     <= 1'b0;
        end else if (Clear) begin
            r_state <= EMPTY;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_bfb   <= '0;
            r_opcnt <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_data[r_wptr] <= ALUout;
                r_func[r_wptr] <= Function;
                r_wptr         <= ~r_wptr;
                r_bfb          <= ALUout[N-1:0];
                r_opcnt        <= r_opcnt + 8'd1;
                if ((Function == 2'd0) && (ALUout[2*N-1:N] != '0))
                    r_ovf <= 1'b1;
            end
            if (w_pop)
                r_rptr <= ~r_rptr;

            case (r_state)
                EMPTY: if (w_push) r_state <= ONE;
                ONE: begin
                    if (w_push && !w_pop)      r_state <= FULL;
                    else if (w_pop && !w_push) r_state <= EMPTY;
                end
                FULL:  if (w_pop) r_state <= ONE;
                default: r_state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed vector table, hand sequences for wrap and
// async reset, and a randomized phase checked against a queue-based model.
module tb_alu_result_stage;

    logic       Clock = 1'b0;
    logic       Reset_b;
    logic       Clear;
    logic [7:0] ALUout;
    logic [1:0] Function;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] Result;
    logic [1:0] FuncOut;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] B_fb;
    logic [7:0] OpCount;
    logic       Overflow;

    int total = 0;
    int bad   = 0;

    alu_result_stage #(.N(4)) dut (
        .Clock(Clock), .Reset_b(Reset_b), .Clear(Clear),
        .ALUout(ALUout), .Function(Function), .in_valid(in_valid),
        .in_ready(in_ready), .Result(Result), .FuncOut(FuncOut),
        .out_valid(out_valid), .out_ready(out_ready), .B_fb(B_fb),
        .OpCount(OpCount), .Overflow(Overflow)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       clr;
        logic       vld;
        logic [7:0] din;
        logic [1:0] fn;
        logic       ordy;
        logic       e_ov;
        logic [7:0] e_res;
        logic [7:0] e_op;
        logic       e_ovf;
        logic [3:0] e_bfb;
        logic       e_ir;
    } vec_t;

    vec_t vecs [16];

    task automatic idle();
        Clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ALUout = '0; Function = '0;
    endtask

    // queue-based model for the random phase
    logic [9:0] q [$];
    int         m_op;
    int         m_ovf;
    int         m_bfb;
    logic       m_ir;
    logic       acc, pop;

    initial begin
        idle();
        Reset_b = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_result", Result, 8'h00);
        chk("rst_funcout", FuncOut, 2'd0);
        chk("rst_bfb", B_fb, 4'h0);
        chk("rst_opcount", OpCount, 8'd0);
        chk("rst_overflow", Overflow, 1'b0);
        Reset_b = 1'b1;
        @(posedge Clock); #1;

        //                clr vld din    fn ordy  ov res   op    ovf bfb   ir
        vecs[0]  = '{1'b0,1'b1,8'h0C,2'd0,1'b0, 1'b1,8'h0C,8'd1,1'b0,4'hC,1'b1};
        vecs[1]  = '{1'b1,1'b0,8'h00,2'd0,1'b0, 1'b0,8'h00,8'd0,1'b0,4'h0,1'b1};
        vecs[2]  = '{1'b0,1'b1,8'h21,2'd1,1'b0, 1'b1,8'h21,8'd1,1'b0,4'h1,1'b1};
        vecs[3]  = '{1'b0,1'b1,8'h43,2'd1,1'b0, 1'b1,8'h21,8'd2,1'b0,4'h3,1'b0};
        vecs[4]  = '{1'b0,1'b1,8'h65,2'd1,1'b0, 1'b1,8'h21,8'd2,1'b0,4'h3,1'b0};
        vecs[5]  = '{1'b0,1'b0,8'h00,2'd0,1'b1, 1'b1,8'h43,8'd2,1'b0,4'h3,1'b1};
        vecs[6]  = '{1'b0,1'b0,8'h00,2'd0,1'b1, 1'b0,8'h00,8'd2,1'b0,4'h3,1'b1};
        vecs[7]  = '{1'b0,1'b1,8'h12,2'd0,1'b0, 1'b1,8'h12,8'd3,1'b1,4'h2,1'b1};
        vecs[8]  = '{1'b0,1'b1,8'h05,2'd0,1'b1, 1'b1,8'h05,8'd4,1'b1,4'h5,1'b1};
        vecs[9]  = '{1'b0,1'b1,8'hF0,2'd3,1'b0, 1'b1,8'h05,8'd5,1'b1,4'h0,1'b0};
        vecs[10] = '{1'b1,1'b1,8'h33,2'd0,1'b1, 1'b0,8'h00,8'd0,1'b0,4'h0,1'b1};
        vecs[11] = '{1'b0,1'b1,8'h07,2'd2,1'b0, 1'b1,8'h07,8'd1,1'b0,4'h7,1'b1};
        vecs[12] = '{1'b0,1'b1,8'h09,2'd2,1'b1, 1'b1,8'h09,8'd2,1'b0,4'h9,1'b1};
        vecs[13] = '{1'b0,1'b1,8'h1F,2'd0,1'b0, 1'b1,8'h09,8'd3,1'b1,4'hF,1'b0};
        vecs[14] = '{1'b0,1'b1,8'hAA,2'd0,1'b1, 1'b1,8'h1F,8'd3,1'b1,4'hF,1'b1};
        vecs[15] = '{1'b0,1'b0,8'h00,2'd0,1'b1, 1'b0,8'h00,8'd3,1'b1,4'hF,1'b1};

        for (int i = 0; i < 16; i++) begin
            Clear = vecs[i].clr; in_valid = vecs[i].vld; ALUout = vecs[i].din;
            Function = vecs[i].fn; out_ready = vecs[i].ordy;
            @(posedge Clock); #1;
            idle();
            #1;
            chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
            if (vecs[i].e_ov)
                chk($sformatf("v%0d_result", i), Result, vecs[i].e_res);
            chk($sformatf("v%0d_opcount", i), OpCount, vecs[i].e_op);
            chk($sformatf("v%0d_overflow", i), Overflow, vecs[i].e_ovf);
            chk($sformatf("v%0d_bfb", i), B_fb, vecs[i].e_bfb);
            chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
        end

        // Clear masks in_ready combinationally
        Clear = 1'b1; #1;
        chk("clear_in_ready", in_ready, 1'b0);
        @(posedge Clock); #1; idle();

        // 256 back-to-back accepts wrap the counter
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1; out_ready = 1'b1; Function = 2'd1; ALUout = 8'(i);
            @(posedge Clock); #1;
        end
        idle(); #1;
        chk("wrap_opcount", OpCount, 8'd0);
        chk("wrap_bfb", B_fb, 4'hF);
        chk("wrap_result", Result, 8'hFF);
        chk("wrap_funcout", FuncOut, 2'd1);
        chk("wrap_overflow", Overflow, 1'b0);

        // async reset while FULL
        in_valid = 1'b1; ALUout = 8'h5A; Function = 2'd0;
        @(posedge Clock); #1;
        ALUout = 8'hA5;
        @(posedge Clock); #1; idle(); #1;
        chk("pre_rst_full_in_ready", in_ready, 1'b0);
        chk("pre_rst_overflow", Overflow, 1'b1);
        #2 Reset_b = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_result", Result, 8'h00);
        chk("arst_opcount", OpCount, 8'd0);
        chk("arst_bfb", B_fb, 4'h0);
        chk("arst_overflow", Overflow, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        @(negedge Clock); Reset_b = 1'b1;
        @(posedge Clock); #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_out_valid", out_valid, 1'b0);

        // randomized phase against the queue model
        q.delete(); m_op = 0; m_ovf = 0; m_bfb = 0; m_ir = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (!(in_valid && !m_ir)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                ALUout   = 8'($urandom);
                Function = 2'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            Clear     = ($urandom_range(0, 40) == 0);
            #1;
            m_ir = (q.size() < 2) && !Clear;
            chk("rnd_in_ready", in_ready, m_ir);
            acc = in_valid && m_ir;
            pop = (q.size() > 0) && out_ready && !Clear;
            @(posedge Clock);
            if (Clear) begin
                q.delete(); m_op = 0; m_ovf = 0; m_bfb = 0;
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) begin
                    q.push_back({Function, ALUout});
                    m_op  = (m_op + 1) % 256;
                    m_bfb = ALUout % 16;
                    if (Function == 2'd0 && ALUout >= 16) m_ovf = 1;
                end
            end
            #1;
            chk("rnd_out_valid", out_valid, (q.size() > 0));
            if (q.size() > 0) begin
                chk("rnd_result", Result, q[0][7:0]);
                chk("rnd_funcout", FuncOut, q[0][9:8]);
            end
            chk("rnd_opcount", OpCount, m_op);
            chk("rnd_bfb", B_fb, m_bfb);
            chk("rnd_overflow", Overflow, m_ovf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
